// File: rtl/mips_trace_pkg.sv
// Shared definitions for the Mips trace monitor: capture state encoding and
// the trace entry layout {channel, data, timestamp}, with the timestamp in the LSBs.
package mips_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int TS_OFS = 0;

  function automatic int chan_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int data_ofs(input int ts_w);
    return TS_OFS + ts_w;
  endfunction

  function automatic int chan_ofs(input int data_w, input int ts_w);
    return data_ofs(ts_w) + data_w;
  endfunction

  function automatic int entry_width(input int chan_w, input int data_w, input int ts_w);
    return chan_ofs(data_w, ts_w) + chan_w;
  endfunction

endpackage

// File: rtl/mips_trace_fifo.sv
// Synchronous first-word-fall-through FIFO; the head entry is visible as soon as
// it is written, and a pop at the same edge frees room for a push into a full FIFO.
module mips_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices coincide.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/mips_trace_monitor.sv
// Records value changes on CHANNELS probe buses with a cycle timestamp into a trace FIFO.
// Optional build macro MIPS_TRACE_DROP_CNT_EN enables the saturating dropped-event counter.
module mips_trace_monitor
  import mips_trace_pkg::*;
#(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int TS_WIDTH   = 16,
  parameter int RUN_CYCLES = 0
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic [CHANNELS-1:0]                  ch_mask,
  input  logic [CHANNELS*DATA_WIDTH-1:0]       ch_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [chan_width(CHANNELS)-1:0]      out_channel,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [TS_WIDTH-1:0]                  out_timestamp,
  output logic                                 running,
  output logic                                 done,
  output logic                                 overflow,
  output logic [7:0]                           drop_count
);

  localparam int CW    = chan_width(CHANNELS);
  localparam int EW    = entry_width(CW, DATA_WIDTH, TS_WIDTH);
  localparam int D_OFS = data_ofs(TS_WIDTH);
  localparam int C_OFS = chan_ofs(DATA_WIDTH, TS_WIDTH);
  localparam logic [TS_WIDTH-1:0] LAST_TS =
    (RUN_CYCLES == 0) ? '0 : TS_WIDTH'(RUN_CYCLES - 1);

  if (RUN_CYCLES < 0 || longint'(RUN_CYCLES) > (longint'(1) << TS_WIDTH)) begin : g_bad_run_cycles
    $error("RUN_CYCLES does not fit the timestamp range");
  end

  state_t                state;
  state_t                state_nxt;
  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] chan     [CHANNELS];
  logic [DATA_WIDTH-1:0] snapshot [CHANNELS];
  logic [CHANNELS-1:0]   pending;
  logic                  any_pending;
  logic [CW-1:0]         sel;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic                  lost;
  logic [EW-1:0]         wr_entry;
  logic [EW-1:0]         rd_entry;

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) chan[i] = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // Fixed priority: scanning downward leaves the lowest pending index selected.
  always_comb begin
    pending     = '0;
    any_pending = 1'b0;
    sel         = '0;
    sel_data    = '0;
    for (int i = 0; i < CHANNELS; i++) pending[i] = ch_mask[i] && (chan[i] != snapshot[i]);
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        any_pending = 1'b1;
        sel         = CW'(i);
        sel_data    = chan[i];
      end
    end
  end

  assign pop       = out_valid && out_ready;
  assign push      = (state == ST_RUN) && any_pending && (!fifo_full || pop);
  assign lost      = (state == ST_RUN) && any_pending && fifo_full && !pop;
  assign wr_entry  = {sel, sel_data, ts};
  assign out_valid = !fifo_empty;
  assign running   = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  assign out_channel   = rd_entry[C_OFS +: CW];
  assign out_data      = rd_entry[D_OFS +: DATA_WIDTH];
  assign out_timestamp = rd_entry[TS_OFS +: TS_WIDTH];

  mips_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_entry),
    .pop     (pop),
    .rd_data (rd_entry),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (enable) state_nxt = ST_ARM;
      ST_ARM:  state_nxt = ST_RUN;
      ST_RUN: begin
        if (!enable)                                  state_nxt = ST_IDLE;
        else if (RUN_CYCLES != 0 && ts == LAST_TS)    state_nxt = ST_DONE;
      end
      ST_DONE: if (!enable) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ts       <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) snapshot[i] <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_ARM) begin
        ts <= '0;
        for (int i = 0; i < CHANNELS; i++) snapshot[i] <= chan[i];
      end else if (state == ST_RUN) begin
        if (ts != '1) ts <= ts + 1'b1;
        // A blocked push leaves the snapshot alone so the channel retries next cycle.
        for (int i = 0; i < CHANNELS; i++) begin
          if (push && sel == CW'(i)) snapshot[i] <= chan[i];
        end
      end
      if (lost) overflow <= 1'b1;
    end
  end

`ifdef MIPS_TRACE_DROP_CNT_EN
  always_ff @(posedge clock) begin
    if (!reset)                                        drop_count <= '0;
    else if (state == ST_IDLE && state_nxt == ST_ARM)  drop_count <= '0;
    else if (lost && drop_count != 8'hFF)              drop_count <= drop_count + 1'b1;
  end
`else
  assign drop_count = 8'd0;
`endif

endmodule
